// File: rtl/mem_pkg.sv
// Shared encodings and store-formatting helpers for the data-memory access unit.
package mem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Size 2'b11 falls into the default arms and behaves as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = ~addr_lo[0];
            default:   is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: byte_enables = 4'b0001 << addr_lo;
            SIZE_HALF: byte_enables = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SIZE_BYTE: store_data = {4{d[7:0]}};
            SIZE_HALF: store_data = {2{d[15:0]}};
            default:   store_data = d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane out of a read word and sign-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] load_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (size)
            SIZE_BYTE: load_data = {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{half_sel[15]}}, half_sel};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory handshake: IDLE -> ACCESS (wait for ack) -> DONE,
// with alignment checking, store lane formatting and load sign extension.
module mem_access
    import mem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  Size_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] ReadData2_MEM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        Stall,
    output logic [31:0] LoadData_MEM,
    output logic        Misaligned
);

    state_t      state_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] load_data_reg;
    logic        misaligned_reg;
    logic [1:0]  size_reg;
    logic [1:0]  addr_lo_reg;

    logic        pending;
    logic        aligned;
    logic [31:0] aligned_rdata;

    assign pending = MemRead_MEM | MemWrite_MEM;
    assign aligned = is_aligned(Size_MEM, ALUResult_MEM[1:0]);

    // Size and low address bits are captured at issue so the load lane
    // selection does not depend on EX/MEM staying frozen.
    load_align u_load_align (
        .rdata     (MemRData),
        .addr_lo   (addr_lo_reg),
        .size      (size_reg),
        .load_data (aligned_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_be_reg     <= 4'd0;
            mem_wdata_reg  <= 32'd0;
            load_data_reg  <= 32'd0;
            misaligned_reg <= 1'b0;
            size_reg       <= SIZE_WORD;
            addr_lo_reg    <= 2'b00;
        end else begin
            misaligned_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pending && aligned) begin
                        state_reg     <= ST_ACCESS;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= MemWrite_MEM;
                        mem_addr_reg  <= {ALUResult_MEM[31:2], 2'b00};
                        mem_be_reg    <= byte_enables(Size_MEM, ALUResult_MEM[1:0]);
                        mem_wdata_reg <= store_data(Size_MEM, ReadData2_MEM);
                        size_reg      <= Size_MEM;
                        addr_lo_reg   <= ALUResult_MEM[1:0];
                    end else if (pending) begin
                        misaligned_reg <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (MemAck) begin
                        state_reg   <= ST_DONE;
                        mem_req_reg <= 1'b0;
                        if (!mem_we_reg) begin
                            load_data_reg <= aligned_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Stall = ~Reset &
                   (((state_reg == ST_IDLE) & pending & aligned) | (state_reg == ST_ACCESS));

    assign MemReq       = mem_req_reg;
    assign MemWe        = mem_we_reg;
    assign MemAddr      = mem_addr_reg;
    assign MemBE        = mem_be_reg;
    assign MemWData     = mem_wdata_reg;
    assign LoadData_MEM = load_data_reg;
    assign Misaligned   = misaligned_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [1:0]  Size_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] ReadData2_MEM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        Stall;
    logic [31:0] LoadData_MEM;
    logic        Misaligned;

    int compared   = 0;
    int mismatched = 0;
    int stall_cnt;

    always #5 Clk = ~Clk;

    mem_access dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .MemRead_MEM   (MemRead_MEM),
        .MemWrite_MEM  (MemWrite_MEM),
        .Size_MEM      (Size_MEM),
        .ALUResult_MEM (ALUResult_MEM),
        .ReadData2_MEM (ReadData2_MEM),
        .MemReq        (MemReq),
        .MemWe         (MemWe),
        .MemAddr       (MemAddr),
        .MemBE         (MemBE),
        .MemWData      (MemWData),
        .MemRData      (MemRData),
        .MemAck        (MemAck),
        .Stall         (Stall),
        .LoadData_MEM  (LoadData_MEM),
        .Misaligned    (Misaligned)
    );

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
        $display("check %-22s observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic idle_inputs();
        MemRead_MEM   = 1'b0;
        MemWrite_MEM  = 1'b0;
        Size_MEM      = 2'b00;
        ALUResult_MEM = 32'd0;
        ReadData2_MEM = 32'd0;
        MemAck        = 1'b0;
        MemRData      = 32'd0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata);
        MemRead_MEM   = rd;
        MemWrite_MEM  = wr;
        Size_MEM      = sz;
        ALUResult_MEM = addr;
        ReadData2_MEM = wdata;
        #1;
    endtask

    // Acks the in-flight access in the current cycle, then lands in DONE.
    task automatic ack_now(input logic [31:0] rdata);
        MemAck   = 1'b1;
        MemRData = rdata;
        tick();
        MemAck   = 1'b0;
        MemRData = 32'd0;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        MemRead_MEM = 1'b1;
        tick();
        tick();
        chk("rst_stall_low", {31'd0, Stall}, 32'd0);
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_membe", {28'd0, MemBE}, 32'd0);
        chk("rst_loaddata", LoadData_MEM, 32'd0);
        chk("rst_misaligned", {31'd0, Misaligned}, 32'd0);
        Reset = 1'b0;
        idle_inputs();
        tick();

        // Stray ack while idle must be ignored.
        MemAck = 1'b1; MemRData = 32'h1234_5678;
        tick();
        MemAck = 1'b0; MemRData = 32'd0;
        chk("stray_ack_loaddata", LoadData_MEM, 32'd0);
        chk("stray_ack_memreq", {31'd0, MemReq}, 32'd0);

        // Word load at 0x100, two wait cycles.
        stall_cnt = 0;
        issue(1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'd0);
        stall_cnt += int'(Stall);
        tick();
        chk("wl_memreq", {31'd0, MemReq}, 32'd1);
        chk("wl_memwe", {31'd0, MemWe}, 32'd0);
        chk("wl_memaddr", MemAddr, 32'h0000_0100);
        stall_cnt += int'(Stall);
        tick();
        stall_cnt += int'(Stall);
        tick();
        stall_cnt += int'(Stall);
        ack_now(32'hDEAD_BEEF);
        chk("wl_done_memreq", {31'd0, MemReq}, 32'd0);
        chk("wl_done_stall", {31'd0, Stall}, 32'd0);
        chk("wl_stall_cycles", stall_cnt, 32'd4);
        idle_inputs();
        tick();
        chk("wl_loaddata", LoadData_MEM, 32'hDEAD_BEEF);

        // Byte load at 0x103: lane 3 = 0x80, sign-extended.
        issue(1'b1, 1'b0, 2'b10, 32'h0000_0103, 32'd0);
        tick();
        ack_now(32'h8011_2233);
        chk("bl_loaddata", LoadData_MEM, 32'hFFFF_FF80);
        idle_inputs();
        tick();

        // Half load at 0x102: upper half 0x7FFF stays positive.
        issue(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'd0);
        tick();
        ack_now(32'h7FFF_8000);
        chk("hl_loaddata", LoadData_MEM, 32'h0000_7FFF);
        idle_inputs();
        tick();

        // Byte load at 0x101: lane 1 = 0x7F.
        issue(1'b1, 1'b0, 2'b10, 32'h0000_0101, 32'd0);
        tick();
        ack_now(32'h0000_7F00);
        chk("bl1_loaddata", LoadData_MEM, 32'h0000_007F);
        idle_inputs();
        tick();

        // Half store at 0x102.
        issue(1'b0, 1'b1, 2'b01, 32'h0000_0102, 32'h0000_ABCD);
        chk("hs_stall_idle", {31'd0, Stall}, 32'd1);
        tick();
        chk("hs_memwe", {31'd0, MemWe}, 32'd1);
        chk("hs_memaddr", MemAddr, 32'h0000_0100);
        chk("hs_membe", {28'd0, MemBE}, 32'h0000_000C);
        chk("hs_memwdata", MemWData, 32'hABCD_ABCD);
        ack_now(32'hFFFF_FFFF);
        chk("hs_loaddata_kept", LoadData_MEM, 32'h0000_007F);
        idle_inputs();
        tick();

        // Size 2'b11 store behaves as a word store; read+write counts as write.
        issue(1'b1, 1'b1, 2'b11, 32'h0000_0300, 32'h1122_3344);
        tick();
        chk("ws_memwe", {31'd0, MemWe}, 32'd1);
        chk("ws_membe", {28'd0, MemBE}, 32'h0000_000F);
        chk("ws_memwdata", MemWData, 32'h1122_3344);
        ack_now(32'h5555_5555);
        chk("ws_loaddata_kept", LoadData_MEM, 32'h0000_007F);
        idle_inputs();
        tick();

        // Misaligned word load at 0x101.
        issue(1'b1, 1'b0, 2'b00, 32'h0000_0101, 32'd0);
        chk("mis_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, Misaligned}, 32'd1);
        chk("mis_memreq", {31'd0, MemReq}, 32'd0);
        idle_inputs();
        tick();
        chk("mis_pulse_end", {31'd0, Misaligned}, 32'd0);
        chk("mis_loaddata_kept", LoadData_MEM, 32'h0000_007F);

        // Reset in ACCESS coincident with ack.
        issue(1'b1, 1'b0, 2'b00, 32'h0000_0200, 32'd0);
        tick();
        chk("ra_memreq_before", {31'd0, MemReq}, 32'd1);
        Reset = 1'b1;
        MemAck = 1'b1; MemRData = 32'h1234_5678;
        tick();
        chk("ra_memreq", {31'd0, MemReq}, 32'd0);
        chk("ra_loaddata", LoadData_MEM, 32'd0);
        chk("ra_memaddr", MemAddr, 32'd0);
        chk("ra_stall", {31'd0, Stall}, 32'd0);
        Reset = 1'b0;
        idle_inputs();
        tick();
        chk("ra_idle_memreq", {31'd0, MemReq}, 32'd0);

        // Back-to-back byte store then word load.
        issue(1'b0, 1'b1, 2'b10, 32'h0000_0201, 32'h0000_00A5);
        tick();
        chk("bb_st_membe", {28'd0, MemBE}, 32'h0000_0002);
        chk("bb_st_memwdata", MemWData, 32'hA5A5_A5A5);
        chk("bb_st_memaddr", MemAddr, 32'h0000_0200);
        ack_now(32'd0);
        chk("bb_done_memreq", {31'd0, MemReq}, 32'd0);
        issue(1'b1, 1'b0, 2'b00, 32'h0000_0204, 32'd0);
        tick();
        chk("bb_gap_memreq", {31'd0, MemReq}, 32'd0);
        chk("bb_gap_stall", {31'd0, Stall}, 32'd1);
        tick();
        chk("bb_ld_memreq", {31'd0, MemReq}, 32'd1);
        chk("bb_ld_memwe", {31'd0, MemWe}, 32'd0);
        chk("bb_ld_memaddr", MemAddr, 32'h0000_0204);
        ack_now(32'hCAFE_F00D);
        chk("bb_ld_loaddata", LoadData_MEM, 32'hCAFE_F00D);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
